// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder_pkg                                          |
// | Purpose  : Shared definitions for the serial adder: FSM state        |
// |            encoding, step-count derivation and counter sizing.       |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of clock steps needed to walk WIDTH bits CHUNK at a time.
  function automatic int calc_steps(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Step-counter width; a single-step configuration still needs one bit.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_chunk_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : chunk_adder                                               |
// | Purpose  : Combinational CHUNK-bit adder with carry-in / carry-out.  |
// | Ports    : a, b [CHUNK-1:0] addends; ci carry-in;                    |
// |            s [CHUNK-1:0] sum; co carry-out.                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  generate
    if (CHUNK == 1) begin : g_fa
      // Classic single-bit full-adder cell.
      logic p;
      assign p    = a[0] ^ b[0];
      assign s[0] = p ^ ci;
      assign co   = (a[0] & b[0]) | (p & ci);
    end else begin : g_wide
      logic [CHUNK:0] t;
      assign t       = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
      assign {co, s} = t;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder                                              |
// | Purpose  : Multi-cycle adder computing a+b+cin, CHUNK bits per clock,|
// |            with valid/ready handshakes on operands and result.       |
// | Ports    : clk, rst_n (sync, active-low)                             |
// |            in_valid/in_ready, a, b [WIDTH-1:0], cin   operand side   |
// |            out_valid/out_ready, sum [WIDTH-1:0], cout  result side   |
// |            sub (in), ovf (out)  only with SERIAL_ADDER_SUB_EN        |
// | Options  : SERIAL_ADDER_SUB_EN adds subtract mode and signed ovf.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = calc_steps(WIDTH, CHUNK);
  localparam int CW    = cnt_width(STEPS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a  (a_sh_q[CHUNK-1:0]),
    .b  (b_sh_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b - cin == a + ~b + ~cin in two's complement.
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = ~cin;
          end
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_sh_d[WIDTH-1];
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result fills from the MSB side so it is LSB-aligned after STEPS shifts.
        sum_d                    = sum_q >> CHUNK;
        sum_d[WIDTH-1 -: CHUNK]  = chunk_s;
        a_sh_d                   = a_sh_q >> CHUNK;
        b_sh_d                   = b_sh_q >> CHUNK;
        carry_d                  = chunk_co;
        cnt_d                    = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          cout_d  = chunk_co;
`ifdef SERIAL_ADDER_SUB_EN
          // Signed overflow: like-signed operands producing an opposite-signed sum.
          ovf_d   = (a_msb_q == b_msb_q) && (chunk_s[CHUNK-1] != a_msb_q);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_adder                                           |
// | Purpose  : Self-checking bench for serial_adder (8x1 and 16x4).      |
// |            Build with SERIAL_ADDER_SUB_EN to exercise subtract mode. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- 8-bit, 1-bit-per-clock instance ----------------
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, sub8 = 1'b0, cout8, ovf8;

  // ---------------- 16-bit, 4-bit-per-clock instance ----------------
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, cout16;
`ifdef SERIAL_ADDER_SUB_EN
  logic        ovf16;
`endif

  serial_adder #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8), .ovf(ovf8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0), .ovf(ovf16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16)
  );

`ifndef SERIAL_ADDER_SUB_EN
  assign ovf8 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model for the 8-bit instance ----------------
  // Integer arithmetic: the sum is r mod 256; carry means r overflowed 8 bits
  // for an add, or r did not go negative (no borrow) for a subtract.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
    int r;
    logic co;
    r  = s ? int'(a) - int'(b) - int'(c) : int'(a) + int'(b) + int'(c);
    co = s ? (r >= 0) : (r > 255);
    return {co, r[7:0]};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic s);
    int ia, ib, r;
    ia = a[7] ? int'(a) - 256 : int'(a);
    ib = b[7] ? int'(b) - 256 : int'(b);
    r  = s ? ia - ib - int'(c) : ia + ib + int'(c);
    return (r > 127) || (r < -128);
  endfunction

  // Model: idle -> (accept) busy for 8 clocks -> done until out_ready.
  int         m_busy = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;
  logic       m_ovf  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_done) begin
      if (out_ready8) m_done <= 1'b0;
    end else if (m_busy > 1) begin
      m_busy <= m_busy - 1;
    end else if (m_busy == 1) begin
      m_busy <= 0;
      m_done <= 1'b1;
    end else if (in_valid8) begin
      {m_cout, m_sum} <= ref_add(a8, b8, cin8, sub8);
      m_ovf           <= ref_ovf(a8, b8, cin8, sub8);
      m_busy          <= 8;
    end
  end

  // Compare process: handshake outputs every cycle; result whenever not mid-run.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready8", 32'(in_ready8), 32'(m_busy == 0 && !m_done));
      check("out_valid8", 32'(out_valid8), 32'(m_done));
      if (m_busy == 0) begin
        check("sum8", 32'(sum8), 32'(m_sum));
        check("cout8", 32'(cout8), 32'(m_cout));
`ifdef SERIAL_ADDER_SUB_EN
        check("ovf8", 32'(ovf8), 32'(m_ovf));
`endif
      end
    end
  end

  // Issue one 8-bit transaction, hold backpressure for 'hold' cycles in DONE.
  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, input int hold,
                      output logic [7:0] rs, output logic rc, output logic ro,
                      output int lat);
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; sub8 = s; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = ~a; b8 = ~b;              // later operand changes must be ignored
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready8", 32'(in_ready8), 32'd0);
      check("bp_out_valid8", 32'(out_valid8), 32'd1);
    end
    rs = sum8; rc = cout8; ro = ovf8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("release_in_ready8", 32'(in_ready8), 32'd1);
    check("release_out_valid8", 32'(out_valid8), 32'd0);
  endtask

  logic [7:0] rs;
  logic       rc, ro;
  int         lat;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready8", 32'(in_ready8), 32'd1);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_in_ready16", 32'(in_ready16), 32'd1);

    txn8(8'h00, 8'h00, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    check("zero_sum", 32'(rs), 32'h00);
    check("zero_cout", 32'(rc), 32'd0);
    check("zero_latency", 32'(lat), 32'd8);

    txn8(8'hFF, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    check("wrap_sum", 32'(rs), 32'h00);
    check("wrap_cout", 32'(rc), 32'd1);

    txn8(8'hA5, 8'h5A, 1'b1, 1'b0, 0, rs, rc, ro, lat);
    check("a5_sum", 32'(rs), 32'h00);
    check("a5_cout", 32'(rc), 32'd1);

    txn8(8'h3C, 8'h0F, 1'b0, 1'b0, 5, rs, rc, ro, lat);
    check("bp_sum", 32'(rs), 32'h4B);
    check("bp_cout", 32'(rc), 32'd0);

    txn8(8'hC8, 8'h64, 1'b1, 1'b0, 1, rs, rc, ro, lat);
    check("c8_sum", 32'(rs), 32'h2D);
    check("c8_cout", 32'(rc), 32'd1);

    // Reset asserted during the third RUN cycle.
    @(posedge clk); #1;
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid8", 32'(out_valid8), 32'd0);
    check("midrst_in_ready8", 32'(in_ready8), 32'd1);
    check("midrst_sum8", 32'(sum8), 32'd0);
    repeat (10) @(posedge clk);
    #1 check("midrst_no_result", 32'(out_valid8), 32'd0);

    txn8(8'h12, 8'h34, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    check("after_rst_sum", 32'(rs), 32'h46);
    check("after_rst_cout", 32'(rc), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    txn8(8'h10, 8'h01, 1'b0, 1'b1, 0, rs, rc, ro, lat);
    check("sub_sum", 32'(rs), 32'h0F);
    check("sub_cout", 32'(rc), 32'd1);
    check("sub_ovf", 32'(ro), 32'd0);
    txn8(8'h80, 8'h01, 1'b0, 1'b1, 0, rs, rc, ro, lat);
    check("subovf_sum", 32'(rs), 32'h7F);
    check("subovf_ovf", 32'(ro), 32'd1);
    txn8(8'h01, 8'h02, 1'b0, 1'b1, 0, rs, rc, ro, lat);
    check("borrow_sum", 32'(rs), 32'hFF);
    check("borrow_cout", 32'(rc), 32'd0);
    txn8(8'h7F, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    check("addovf_ovf", 32'(ro), 32'd1);
`endif

    // 16-bit, 4 bits per clock.
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w16_latency", 32'(lat), 32'd4);
    check("w16_sum", 32'(sum16), 32'h0001);
    check("w16_cout", 32'(cout16), 32'd1);
    check("w16_in_ready_done", 32'(in_ready16), 32'd0);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("w16_in_ready_idle", 32'(in_ready16), 32'd1);
    check("w16_out_valid_idle", 32'(out_valid16), 32'd0);

    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h8765; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w16b_sum", 32'(sum16), 32'h9999);
    check("w16b_cout", 32'(cout16), 32'd0);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle successor to the team's single-bit adder cells.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a carry register between cycles.
- Operands in and result out use valid/ready handshakes.
- Sits between operand registers and the datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; WIDTH >= 2.
- CHUNK, 1, bits added per clock; must divide WIDTH exactly. STEPS = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands a/b/cin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
- cout  output  1  registered carry-out.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; step counter, carry register, shift registers, sum and cout all cleared to 0.
  - out_valid=0, in_ready=1 in the cycle after the reset edge.
- in_ready and out_valid are decoded directly from state. No combinational path from in_valid/out_ready to any output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into shift registers and cin into the carry register; clear the counter; go to RUN.
- RUN, one cycle per step:
  - Add the low CHUNK bits of both shift registers plus the carry register.
  - Shift the CHUNK-bit partial sum into the result register from the MSB side.
  - Shift both operand registers right by CHUNK.
  - Store the chunk carry-out in the carry register.
  - Counter increments. After the step with counter==STEPS-1, go to DONE.
- DONE:
  - out_valid=1. sum/cout are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Latency:
  - Operand acceptance at edge E0; out_valid is high in the cycle after edge E0+STEPS.
  - Minimum initiation interval is STEPS+2 cycles. No overlap: in_ready=0 during RUN and DONE.
- in_valid in RUN/DONE is ignored; the upstream holds the operands. a/b changes after acceptance have no effect.
- Wrap-around:
  - The sum is truncated to WIDTH bits.
  - cout is the carry out of bit WIDTH-1, e.g. 0xFF+0x01 gives sum=0x00, cout=1.
- Reset mid-RUN or mid-DONE: the operation is aborted, the result is discarded, and state returns to IDLE with out_valid=0. No partial result is ever presented.
- Reset takes priority over a simultaneous handshake.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input sub (1 bit), captured with the operands.
  - When sub=1, the B operand is complemented at capture and the carry register is loaded with ~cin, so the block computes a-b-cin as a two's-complement add. In that case cout=1 means no borrow.
  - Adds output ovf (1 bit): registered signed overflow, computed from the captured MSBs of A and effective B and the final sum MSB. Reset value 0.
- Not defined: no sub port and no ovf port; behaviour is add-only as described above.

Decomposition:
- Shared include serial_adder_pkg.vh holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the STEPS derivation;
  - the counter-width function (clog2 of STEPS).
- One sub-module, chunk_adder: combinational CHUNK-bit adder with carry-in/carry-out. Instantiated once per RUN datapath. Built from the team's full-adder cell when CHUNK=1.

Test Plan:
- WIDTH=8, CHUNK=1: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0; out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, CHUNK=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: rst_n=0 on the 3rd RUN cycle -> next cycle out_valid=0, in_ready=1, sum=0. The following transaction a=0x12, b=0x34 gives sum=0x46.
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1; latency 4 cycles.
- SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, a=0x10, b=0x01, cin=0 -> sum=0x0F, cout=1, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, ovf=1.
